// File: rtl/divrem_sequencer.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit for EX; DIVREM_EARLY_OUT_EN lets div-by-zero/overflow skip iterations.
// Latency: capture cycle + XLEN restoring steps, result in the one-cycle DONE state (early-out: capture + DONE).
// Backpressure: oStall freezes the whole pipeline until DONE; iFlush or a dropped iStart aborts silently.
module divrem_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            iCLK,
    input  logic            iRST,
    input  logic            iStart,
    input  logic [2:0]      iFunct3,
    input  logic [XLEN-1:0] iA,
    input  logic [XLEN-1:0] iB,
    input  logic            iFlush,
    output logic            oStall,
    output logic            oReady,
    output logic [XLEN-1:0] oResult
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      funct3Q;
    logic [XLEN-1:0] dvd, dvs, rem, origA;
    logic            qNeg, rNeg, divZero, sOvf;

    logic            inSigned, inDivZero, inOvf;
    logic [XLEN-1:0] absA, absB;

    assign inSigned  = (iFunct3 == 3'b100) || (iFunct3 == 3'b110);
    assign absA      = (inSigned && iA[XLEN-1]) ? -iA : iA;
    assign absB      = (inSigned && iB[XLEN-1]) ? -iB : iB;
    assign inDivZero = (iB == '0);
    assign inOvf     = inSigned && (iA == MINV) && (iB == '1);

`ifdef DIVREM_EARLY_OUT_EN
    logic            inIsRem;
    logic [XLEN-1:0] earlyResult;
    assign inIsRem     = (iFunct3 == 3'b110) || (iFunct3 == 3'b111);
    assign earlyResult = inDivZero ? (inIsRem ? iA : '1) : (inIsRem ? '0 : MINV);
`endif

    // One restoring step; a set top bit of the shifted remainder already means it exceeds the divisor.
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff, remNext, quoNext;
    logic            borrow, geq;

    assign shifted       = {rem, dvd[XLEN-1]};
    assign {borrow, diff} = {1'b0, shifted[XLEN-1:0]} - {1'b0, dvs};
    assign geq           = shifted[XLEN] | ~borrow;
    assign remNext       = geq ? diff : shifted[XLEN-1:0];
    assign quoNext       = {dvd[XLEN-2:0], geq};

    logic            isRemQ;
    logic [XLEN-1:0] quoFix, remFix, calcResult;

    assign isRemQ     = (funct3Q == 3'b110) || (funct3Q == 3'b111);
    assign quoFix     = qNeg ? -quoNext : quoNext;
    assign remFix     = rNeg ? -remNext : remNext;
    assign calcResult = divZero ? (isRemQ ? origA : '1) :
                        sOvf    ? (isRemQ ? '0 : MINV) :
                        (isRemQ ? remFix : quoFix);

    assign oStall = iStart && (state != DONE) && !iFlush;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state   <= IDLE;
            cnt     <= '0;
            funct3Q <= '0;
            dvd     <= '0;
            dvs     <= '0;
            rem     <= '0;
            origA   <= '0;
            qNeg    <= 1'b0;
            rNeg    <= 1'b0;
            divZero <= 1'b0;
            sOvf    <= 1'b0;
            oReady  <= 1'b0;
            oResult <= '0;
        end else if (iFlush) begin
            state  <= IDLE;
            oReady <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    oReady <= 1'b0;
                    if (iStart) begin
                        funct3Q <= iFunct3;
                        dvd     <= absA;
                        dvs     <= absB;
                        rem     <= '0;
                        origA   <= iA;
                        qNeg    <= inSigned && (iA[XLEN-1] ^ iB[XLEN-1]);
                        rNeg    <= inSigned && iA[XLEN-1];
                        divZero <= inDivZero;
                        sOvf    <= inOvf;
                        cnt     <= CW'(XLEN);
`ifdef DIVREM_EARLY_OUT_EN
                        if (inDivZero || inOvf) begin
                            state   <= DONE;
                            oResult <= earlyResult;
                            oReady  <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
`else
                        state <= CALC;
`endif
                    end
                end
                CALC: begin
                    if (!iStart) begin
                        state <= IDLE;
                    end else begin
                        rem <= remNext;
                        dvd <= quoNext;
                        cnt <= cnt - CW'(1);
                        if (cnt == CW'(1)) begin
                            state   <= DONE;
                            oResult <= calcResult;
                            oReady  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    oReady <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    oReady <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_divrem_sequencer.sv
// Scoreboard bench for divrem_sequencer: directed corner cases, abort paths and a random sweep.
module tb_divrem_sequencer;
    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iStart;
    logic [2:0]  iFunct3;
    logic [31:0] iA, iB;
    logic        iFlush;
    logic        oStall, oReady;
    logic [31:0] oResult;

    int checks = 0;
    int errors = 0;
    logic [31:0] sbq[$];

`ifdef DIVREM_EARLY_OUT_EN
    localparam int SPECIAL_STALL = 1;
`else
    localparam int SPECIAL_STALL = 33;
`endif
    localparam int NORMAL_STALL = 33;

    divrem_sequencer #(.XLEN(32)) dut (
        .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iFunct3(iFunct3),
        .iA(iA), .iB(iB), .iFlush(iFlush),
        .oStall(oStall), .oReady(oReady), .oResult(oResult)
    );

    always #5 iCLK = ~iCLK;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge iCLK);
        #1;
    endtask

    function automatic logic [31:0] refDivRem(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic isRem, sgn;
        logic signed [31:0] sa, sb;
        isRem = (f == 3'b110) || (f == 3'b111);
        sgn   = (f == 3'b100) || (f == 3'b110);
        sa = a;
        sb = b;
        if (b == 32'd0) return isRem ? a : 32'hFFFF_FFFF;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return isRem ? 32'd0 : 32'h8000_0000;
        if (sgn) return isRem ? 32'(sa % sb) : 32'(sa / sb);
        return isRem ? a % b : a / b;
    endfunction

    function automatic bit isSpecial(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        bit sgn;
        sgn = (f == 3'b100) || (f == 3'b110);
        return (b == 32'd0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Called just after a rising edge; leaves iStart high and returns just after the edge that exits DONE.
    task automatic runOp(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int expStall);
        int  stallCnt;
        bit  done;
        logic [31:0] want;
        stallCnt = 0;
        done = 1'b0;
        sbq.push_back(exp);
        iStart  = 1'b1;
        iFunct3 = f;
        iA      = a;
        iB      = b;
        for (int cyc = 0; cyc < 80 && !done; cyc++) begin
            @(negedge iCLK);
            if (oReady) begin
                done = 1'b1;
                want = sbq.pop_front();
                check({tag, "_res"}, oResult, want);
                check({tag, "_stall_done"}, {31'd0, oStall}, 32'd0);
                check({tag, "_latency"}, stallCnt, expStall);
            end else if (oStall) begin
                stallCnt++;
            end
            nextCycle();
            if (cyc == 0) begin
                iA = $urandom;
                iB = $urandom;
            end
        end
        check({tag, "_completed"}, {31'd0, done}, 32'd1);
        if (!done) void'(sbq.pop_front());
    endtask

    initial begin
        int readyCnt;
        logic [2:0]  f;
        logic [31:0] a, b;

        iRST = 1'b1; iStart = 1'b0; iFunct3 = 3'b000; iA = '0; iB = '0; iFlush = 1'b0;
        repeat (3) nextCycle();
        iRST = 1'b0;
        @(negedge iCLK);
        check("rst_ready", {31'd0, oReady}, 32'd0);
        check("rst_result", oResult, 32'd0);
        check("rst_stall", {31'd0, oStall}, 32'd0);
        nextCycle();

        runOp("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, NORMAL_STALL);
        iStart = 1'b0;
        @(negedge iCLK);
        check("divu_idle_ready", {31'd0, oReady}, 32'd0);
        nextCycle();

        // Back-to-back pairs with no idle gap between them.
        runOp("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, NORMAL_STALL);
        runOp("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, NORMAL_STALL);
        runOp("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPECIAL_STALL);
        runOp("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SPECIAL_STALL);
        runOp("divu_5_0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, SPECIAL_STALL);
        runOp("remu_5_0", 3'b111, 32'd5, 32'd0, 32'd5, SPECIAL_STALL);
        runOp("div_7_0", 3'b100, 32'd7, 32'd0, 32'hFFFF_FFFF, SPECIAL_STALL);
        runOp("rem_m5_0", 3'b110, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, SPECIAL_STALL);
        iStart = 1'b0;
        nextCycle();

        // Flush in the tenth iteration cycle.
        iStart = 1'b1; iFunct3 = 3'b101; iA = 32'd1000; iB = 32'd3;
        repeat (10) nextCycle();
        iFlush = 1'b1;
        @(negedge iCLK);
        check("flush_stall", {31'd0, oStall}, 32'd0);
        readyCnt = oReady ? 1 : 0;
        nextCycle();
        iFlush = 1'b0;
        iStart = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge iCLK);
            if (oReady) readyCnt++;
            nextCycle();
        end
        check("flush_no_ready", readyCnt, 0);
        runOp("divu_9_3", 3'b101, 32'd9, 32'd3, 32'd3, NORMAL_STALL);
        iStart = 1'b0;
        nextCycle();

        // Reset in the twentieth iteration cycle.
        iStart = 1'b1; iFunct3 = 3'b101; iA = 32'd1000; iB = 32'd3;
        repeat (20) nextCycle();
        iRST = 1'b1;
        nextCycle();
        iRST = 1'b0;
        iStart = 1'b0;
        @(negedge iCLK);
        check("midrst_ready", {31'd0, oReady}, 32'd0);
        check("midrst_result", oResult, 32'd0);
        nextCycle();
        runOp("remu_10_4", 3'b111, 32'd10, 32'd4, 32'd2, NORMAL_STALL);
        iStart = 1'b0;
        nextCycle();

        for (int i = 0; i < 12; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : $urandom;
            if (i == 3) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; f = 3'b110; end
            if (i == 5) b = b >> $urandom_range(0, 31);
            runOp($sformatf("rand%0d", i), f, a, b, refDivRem(f, a, b),
                  isSpecial(f, a, b) ? SPECIAL_STALL : NORMAL_STALL);
            if (i % 3 == 0) begin
                iStart = 1'b0;
                nextCycle();
            end
        end
        iStart = 1'b0;
        nextCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/divrem_sequencer.md
# divrem_sequencer

Multi-cycle controller and iterative datapath for RV32M DIV/DIVU/REM/REMU in the EX stage. It replaces the fixed-count EX stall with a handshake: it holds the pipeline stalled until the quotient or remainder is actually ready, then presents the result for exactly one cycle. It sits beside the EX-stage ALU. Its stall request feeds the forward/hazard unit's full-pipeline freeze.

## Interface
Parameters:
- XLEN, 32, operand/result width; the iteration count equals XLEN.

Ports:
- iCLK  in  1  clock; all state updates on the rising edge.
- iRST  in  1  reset, synchronous, active-high.
- iStart  in  1  EX holds a DIV/REM instruction (EX-stage DivRem type bit).
- iFunct3  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU; other codes are treated as DIVU.
- iA  in  XLEN  dividend (forwarded rs1).
- iB  in  XLEN  divisor (forwarded rs2).
- iFlush  in  1  abort the current operation (exception/flush of EX).
- oStall  out  1  combinational; freeze the whole pipeline this cycle.
- oReady  out  1  registered; result valid this cycle.
- oResult  out  XLEN  registered; quotient or remainder per the latched funct3.

## Operation
- States: IDLE, CALC, DONE.
- Reset (iRST=1): state IDLE, counter 0, oReady 0, oResult 0, all internal registers 0. This also applies mid-operation and overrides every other input.
- IDLE with iStart=1 and iFlush=0:
  - Latch funct3.
  - Latch |iA| and |iB| (absolute value only for signed ops).
  - Latch the quotient sign = sign(iA) XOR sign(iB) and the remainder sign = sign(iA).
  - Clear the partial remainder, load the counter with XLEN, go to CALC.
- CALC, one restoring step per cycle:
  - rem = {rem, dividend MSB}.
  - If rem >= divisor: subtract and shift a 1 into the quotient; otherwise shift a 0.
  - Decrement the counter; when it reaches 1, the next state is DONE.
  - Subtraction width is XLEN+1 bits, so the carry-out is the compare result.
- Entering DONE, oResult is loaded as follows; sign fix-up uses two's-complement negation:
  - Divisor == 0: quotient = all ones, remainder = iA (original, unsigned-cast).
  - Signed op with iA = 0x80000000 and iB = all ones: quotient = 0x80000000, remainder = 0.
  - Otherwise: the signed-corrected quotient or remainder.
  - oReady is set to 1.
- DONE: lasts exactly one cycle, then unconditionally IDLE with oReady cleared; oResult holds its value.
- oStall = iStart AND NOT (state==DONE) AND NOT iFlush.
- iFlush=1 in any state: next state IDLE, oReady 0, no result is produced, oStall 0 this cycle.
- iStart dropping to 0 while in CALC is also treated as an abort (go to IDLE).

## Timing
- The operand capture cycle is the first cycle iStart=1 in IDLE; oStall=1 in that cycle.
- Normal latency: capture cycle, then XLEN CALC cycles, then DONE. oStall is high for XLEN+1 cycles and low in the DONE cycle, where EX writes oResult into EX/MEM.
- Back-to-back DIV/REM: the next instruction enters EX the cycle after DONE and finds IDLE. It is stalled and captured normally, with no dead cycle beyond the capture cycle.
- oResult and oReady are registered; only oStall is combinational from iStart, iFlush and the state.

## Configuration
- DIVREM_EARLY_OUT_EN defined:
  - In IDLE, divide-by-zero and signed overflow go directly to DONE with the special result.
  - oStall is high for 1 cycle only.
- Not defined: these cases run the full XLEN iterations, and the special result is substituted when entering DONE (same architectural result, normal latency).

## Test plan
- DIVU 100 / 7 (iFunct3=101), iStart held: oStall=1 for 33 cycles. In the DONE cycle oReady=1, oResult=14, oStall=0. Back to IDLE next cycle.
- REM -7 / 2 (iA=0xFFFFFFF9, iB=2, iFunct3=110): oResult=0xFFFFFFFF (-1). DIV of the same operands gives 0xFFFFFFFD (-3).
- DIV 0x80000000 / 0xFFFFFFFF: oResult=0x80000000 and REM gives 0. Stall is 1 cycle with DIVREM_EARLY_OUT_EN defined, 33 cycles without.
- DIVU 5 / 0: oResult=0xFFFFFFFF. REMU 5 / 0: oResult=5. Stall length depends on the macro as above.
- Assert iFlush in CALC cycle 10: oStall=0 that cycle, state IDLE next cycle, oReady never asserts. A new DIVU 9/3 after that returns 3.
- Assert iRST in CALC cycle 20: next cycle oReady=0, oResult=0, IDLE. A subsequent REMU 10/4 returns 2 after the normal latency.
